// File: rtl/chef_life_sequencer.sv
// chef_life_sequencer: frame-rate game-flow controller for the chef.
// Runs the start / play / death / respawn / game-over sequence. It gates the
// keycode the chef sees, issues the one-frame hurt and chef_reset pulses, and
// produces post-respawn invulnerability with a sprite blink. Enemies are frozen
// while the chef is dying or respawning.
//
// Ports:
//   frame_clk   in   1  frame-rate clock, rising edge active
//   Reset       in   1  asynchronous, active-high reset
//   keycode     in   8  raw keyboard keycode
//   collision   in   1  chef overlaps an enemy this frame (level)
//   lives_in    in   2  chef's remaining lives
//   keycode_out out  8  keycode forwarded to the chef (zero outside PLAY)
//   hurt        out  2  2'b01 for exactly one frame per death
//   chef_reset  out  1  one-frame pulse restoring the chef at game start
//   freeze      out  1  high in DYING and RESPAWN
//   blink       out  1  sprite suppress while invulnerable
//   game_over   out  1  high in OVER
//   state       out  3  IDLE=0, PLAY=1, DYING=2, RESPAWN=3, OVER=4
module chef_life_sequencer #(
    parameter logic [7:0]  START_KEY      = 8'h2C,
    parameter int unsigned DEATH_FRAMES   = 120,
    parameter int unsigned RESPAWN_FRAMES = 60,
    parameter int unsigned INVULN_FRAMES  = 90
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       collision,
    input  logic [1:0] lives_in,
    output logic [7:0] keycode_out,
    output logic [1:0] hurt,
    output logic       chef_reset,
    output logic       freeze,
    output logic       blink,
    output logic       game_over,
    output logic [2:0] state
);

    localparam int unsigned KEY_W   = 8;
    localparam int unsigned TIMER_W = 8;

    localparam logic [TIMER_W-1:0] DEATH_LOAD   = TIMER_W'(DEATH_FRAMES - 1);
    localparam logic [TIMER_W-1:0] RESPAWN_LOAD = TIMER_W'(RESPAWN_FRAMES - 1);
    localparam logic [TIMER_W-1:0] INVULN_LOAD  = TIMER_W'(INVULN_FRAMES);
    localparam logic [TIMER_W-1:0] ONE          = TIMER_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PLAY    = 3'd1,
        S_DYING   = 3'd2,
        S_RESPAWN = 3'd3,
        S_OVER    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [TIMER_W-1:0] inv_q, inv_d;
    logic [KEY_W-1:0]   prev_key_q;
    logic [1:0]         hurt_q, hurt_d;
    logic               chef_reset_q, chef_reset_d;
    logic               freeze_q, freeze_d;
    logic               blink_q, blink_d;
    logic               game_over_q, game_over_d;
    logic               start_edge;

    // Press of the start key; a held key never re-triggers.
    assign start_edge = (keycode == START_KEY) && (prev_key_q != START_KEY);

    // State and output registers.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            inv_q        <= '0;
            prev_key_q   <= '0;
            hurt_q       <= '0;
            chef_reset_q <= 1'b0;
            freeze_q     <= 1'b0;
            blink_q      <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            inv_q        <= inv_d;
            prev_key_q   <= keycode;
            hurt_q       <= hurt_d;
            chef_reset_q <= chef_reset_d;
            freeze_q     <= freeze_d;
            blink_q      <= blink_d;
            game_over_q  <= game_over_d;
        end
    end

    // Next-state, timers and next values of the registered outputs.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        inv_d        = inv_q;
        hurt_d       = 2'b00;
        chef_reset_d = 1'b0;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_edge) begin
                    chef_reset_d = 1'b1;
                    inv_d        = '0;
                    state_d      = S_PLAY;
                end
            end
            S_PLAY: begin
                // The frame that takes inv_cnt from 1 to 0 still ignores collision.
                if (inv_q != '0) begin
                    inv_d = inv_q - ONE;
                end else if (collision) begin
                    hurt_d  = 2'b01;
                    timer_d = DEATH_LOAD;
                    state_d = S_DYING;
                end
            end
            S_DYING: begin
                // lives_in has been updated by the chef well before the timer expires.
                if (timer_q == '0) begin
                    if (lives_in == 2'd0) begin
                        state_d = S_OVER;
                    end else begin
                        timer_d = RESPAWN_LOAD;
                        state_d = S_RESPAWN;
                    end
                end else begin
                    timer_d = timer_q - ONE;
                end
            end
            S_RESPAWN: begin
                if (timer_q == '0) begin
                    inv_d   = INVULN_LOAD;
                    state_d = S_PLAY;
                end else begin
                    timer_d = timer_q - ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        freeze_d    = (state_d == S_DYING) || (state_d == S_RESPAWN);
        game_over_d = (state_d == S_OVER);
        blink_d     = (inv_d != '0) && inv_d[2];
    end

    assign keycode_out = (state_q == S_PLAY) ? keycode : '0;
    assign hurt        = hurt_q;
    assign chef_reset  = chef_reset_q;
    assign freeze      = freeze_q;
    assign blink       = blink_q;
    assign game_over   = game_over_q;
    assign state       = state_q;

endmodule
